// File: rtl/tlb_op_ctrl_pkg.sv
// Shared types for the TLB maintenance sequencer: op codes, controller states
// and the physical-translation field bundle carried by TLBELO0/1.
package tlb_op_ctrl_pkg;

    localparam int         TLBNUM     = 16;
    localparam int         TLBNUMSIZE = 4;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } PhytranItem;

    typedef enum logic [2:0] {
        TLBOP_SRCH = 3'd0,
        TLBOP_RD   = 3'd1,
        TLBOP_WR   = 3'd2,
        TLBOP_FILL = 3'd3,
        TLBOP_INV  = 3'd4
    } TlbOp;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SRCH  = 3'd1,
        ST_RD    = 3'd2,
        ST_WB    = 3'd3,
        ST_WRITE = 3'd4,
        ST_INV   = 3'd5
    } TlbCtrlState;

endpackage

// File: rtl/tlb_op_ctrl_fill_ptr.sv
// Round-robin victim pointer for TLBFILL; advances once per fill write and
// wraps from the last entry back to entry 0.
module tlb_fill_ptr #(
    parameter int TLBNUM     = tlb_op_ctrl_pkg::TLBNUM,
    parameter int TLBNUMSIZE = tlb_op_ctrl_pkg::TLBNUMSIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [TLBNUMSIZE-1:0] ptr
);

    localparam logic [TLBNUMSIZE-1:0] LAST_IDX = TLBNUMSIZE'(TLBNUM - 1);

    logic [TLBNUMSIZE-1:0] ptr_r;

    // Pointer register with explicit wrap so non-power-of-two sizes also work
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (inc) begin
            ptr_r <= (ptr_r == LAST_IDX) ? '0 : ptr_r + TLBNUMSIZE'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB from MEM onto the TLB search-1,
// read, write and flush ports and returns results as CSR write strobes.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLBNUM     = tlb_op_ctrl_pkg::TLBNUM,
    parameter int TLBNUMSIZE = tlb_op_ctrl_pkg::TLBNUMSIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [2:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [18:0]           inv_va,
    input  logic [9:0]            csr_asid,
    input  logic [18:0]           csr_ehi_vppn,
    input  logic [TLBNUMSIZE-1:0] csr_idx,
    input  logic [5:0]            csr_ps,
    input  logic                  csr_ne,
    input  PhytranItem            csr_elo0,
    input  PhytranItem            csr_elo1,
    input  logic                  csr_g0,
    input  logic                  csr_g1,
    input  logic                  csr_refill,
    output logic                  s1_req,
    output logic [18:0]           s1_vppn,
    output logic [9:0]            s1_asid,
    input  logic [TLBNUMSIZE-1:0] s1_index,
    input  logic                  s1_ne,
    output logic [TLBNUMSIZE-1:0] r_index,
    input  logic [5:0]            r_ps,
    input  logic [9:0]            r_asid,
    input  logic                  r_ne,
    input  logic                  r_g,
    input  logic [18:0]           r_vppn,
    input  PhytranItem            r_phytran0,
    input  PhytranItem            r_phytran1,
    output logic                  we,
    output logic [TLBNUMSIZE-1:0] w_index,
    output logic [5:0]            w_ps,
    output logic                  w_ne,
    output logic [9:0]            w_asid,
    output logic [18:0]           w_vppn,
    output logic                  w_g,
    output PhytranItem            w_phytran0,
    output PhytranItem            w_phytran1,
    output logic                  fe,
    output logic [2:0]            f_op,
    output logic [9:0]            f_asid,
    output logic [18:0]           f_va,
    output logic                  srch_we,
    output logic [TLBNUMSIZE-1:0] srch_idx,
    output logic                  srch_ne,
    output logic                  rd_we,
    output logic [5:0]            rd_ps,
    output logic [9:0]            rd_asid,
    output logic                  rd_ne,
    output logic                  rd_g,
    output logic [18:0]           rd_vppn,
    output PhytranItem            rd_phytran0,
    output PhytranItem            rd_phytran1,
    output logic                  done
);

    TlbCtrlState state_r, state_s;

    logic accept_s, latch_s, ill_s, cap_srch_s, cap_rd_s, fill_inc_s;
    logic s1_req_s, srch_we_s, rd_we_s, we_s, fe_s, done_s;
    logic ill_done_r;

    TlbOp                  op_r;
    logic [2:0]            inv_op_r;
    logic [9:0]            inv_asid_r, asid_r;
    logic [18:0]           inv_va_r, vppn_r;
    logic [TLBNUMSIZE-1:0] idx_r, fill_ptr_s, srch_idx_r;
    logic [5:0]            ps_r, rd_ps_r;
    logic                  ne_r, g0_r, g1_r, refill_r, srch_ne_r;
    PhytranItem            elo0_r, elo1_r, rd_p0_r, rd_p1_r;
    logic [9:0]            rd_asid_r;
    logic                  rd_ne_r, rd_g_r;
    logic [18:0]           rd_vppn_r;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        ill_s      = 1'b0;
        cap_srch_s = 1'b0;
        cap_rd_s   = 1'b0;
        fill_inc_s = 1'b0;
        s1_req_s   = 1'b0;
        srch_we_s  = 1'b0;
        rd_we_s    = 1'b0;
        we_s       = 1'b0;
        fe_s       = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    accept_s = 1'b1;
                    case (TlbOp'(op_code))
                        TLBOP_SRCH: state_s = ST_SRCH;
                        TLBOP_RD:   state_s = ST_RD;
                        TLBOP_WR:   state_s = ST_WRITE;
                        TLBOP_FILL: state_s = ST_WRITE;
                        TLBOP_INV:  state_s = ST_INV;
                        default: begin
                            ill_s   = 1'b1;
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SRCH: begin
                s1_req_s   = 1'b1;
                cap_srch_s = 1'b1;
                state_s    = ST_WB;
            end
            ST_RD: begin
                cap_rd_s = 1'b1;
                state_s  = ST_WB;
            end
            ST_WB: begin
                done_s = 1'b1;
                if (op_r == TLBOP_SRCH) begin
                    srch_we_s = 1'b1;
                end else begin
                    rd_we_s = 1'b1;
                end
                state_s = ST_IDLE;
            end
            ST_WRITE: begin
                we_s       = 1'b1;
                done_s     = 1'b1;
                fill_inc_s = (op_r == TLBOP_FILL);
                state_s    = ST_IDLE;
            end
            ST_INV: begin
                fe_s    = 1'b1;
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Illegal ops leave the op registers untouched so no TLB-facing field moves
    assign latch_s = accept_s & ~ill_s;

    // Op and CSR snapshot taken on the accepting edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_r       <= TLBOP_SRCH;
            inv_op_r   <= 3'd0;
            inv_asid_r <= 10'd0;
            inv_va_r   <= 19'd0;
            asid_r     <= 10'd0;
            vppn_r     <= 19'd0;
            idx_r      <= '0;
            ps_r       <= 6'd0;
            ne_r       <= 1'b0;
            elo0_r     <= '0;
            elo1_r     <= '0;
            g0_r       <= 1'b0;
            g1_r       <= 1'b0;
            refill_r   <= 1'b0;
        end else if (latch_s) begin
            op_r       <= TlbOp'(op_code);
            inv_op_r   <= inv_op;
            inv_asid_r <= inv_asid;
            inv_va_r   <= inv_va;
            asid_r     <= csr_asid;
            vppn_r     <= csr_ehi_vppn;
            idx_r      <= csr_idx;
            ps_r       <= csr_ps;
            ne_r       <= csr_ne;
            elo0_r     <= csr_elo0;
            elo1_r     <= csr_elo1;
            g0_r       <= csr_g0;
            g1_r       <= csr_g1;
            refill_r   <= csr_refill;
        end
    end

    // Search/read result capture and the illegal-op done pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            ill_done_r <= 1'b0;
            srch_idx_r <= '0;
            srch_ne_r  <= 1'b0;
            rd_ps_r    <= 6'd0;
            rd_asid_r  <= 10'd0;
            rd_ne_r    <= 1'b0;
            rd_g_r     <= 1'b0;
            rd_vppn_r  <= 19'd0;
            rd_p0_r    <= '0;
            rd_p1_r    <= '0;
        end else begin
            ill_done_r <= ill_s;
            if (cap_srch_s) begin
                srch_idx_r <= s1_index;
                srch_ne_r  <= s1_ne;
            end
            if (cap_rd_s) begin
                rd_ps_r   <= r_ps;
                rd_asid_r <= r_asid;
                rd_ne_r   <= r_ne;
                rd_g_r    <= r_g;
                rd_vppn_r <= r_vppn;
                rd_p0_r   <= r_phytran0;
                rd_p1_r   <= r_phytran1;
            end
        end
    end

    tlb_fill_ptr #(
        .TLBNUM     (TLBNUM),
        .TLBNUMSIZE (TLBNUMSIZE)
    ) u_fill_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (fill_inc_s),
        .ptr   (fill_ptr_s)
    );

    assign op_ready = (state_r == ST_IDLE);
    assign s1_req   = s1_req_s;
    assign srch_we  = srch_we_s;
    assign rd_we    = rd_we_s;
    assign we       = we_s;
    assign fe       = fe_s;
    assign done     = done_s | ill_done_r;

    assign s1_vppn = vppn_r;
    assign s1_asid = asid_r;
    assign r_index = idx_r;

    // A refill handler always installs a valid entry regardless of TLBIDX.NE
    assign w_index    = (op_r == TLBOP_FILL) ? fill_ptr_s : idx_r;
    assign w_ne       = refill_r ? 1'b0 : ne_r;
    assign w_g        = g0_r & g1_r;
    assign w_asid     = asid_r;
    assign w_vppn     = vppn_r;
    assign w_ps       = ps_r;
    assign w_phytran0 = elo0_r;
    assign w_phytran1 = elo1_r;

    assign f_op   = inv_op_r;
    assign f_asid = inv_asid_r;
    assign f_va   = inv_va_r;

    assign srch_idx    = srch_idx_r;
    assign srch_ne     = srch_ne_r;
    assign rd_ps       = rd_ps_r;
    assign rd_asid     = rd_asid_r;
    assign rd_ne       = rd_ne_r;
    assign rd_g        = rd_g_r;
    assign rd_vppn     = rd_vppn_r;
    assign rd_phytran0 = rd_p0_r;
    assign rd_phytran1 = rd_p1_r;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl with a small static TLB responder on the
// search-1 and read ports.
module tb_tlb_op_ctrl;
    import tlb_op_ctrl_pkg::*;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    localparam int K_SRCH = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;
    localparam int K_INV  = 3;
    localparam int K_ILL  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic op_valid = 1'b0, op_ready;
    logic [2:0] op_code = 3'd0, inv_op = 3'd0;
    logic [9:0] inv_asid = 10'd0, csr_asid = 10'd0;
    logic [18:0] inv_va = 19'd0, csr_ehi_vppn = 19'd0;
    logic [3:0] csr_idx = 4'd0;
    logic [5:0] csr_ps = 6'd0;
    logic csr_ne = 1'b0, csr_g0 = 1'b0, csr_g1 = 1'b0, csr_refill = 1'b0;
    PhytranItem csr_elo0 = '0, csr_elo1 = '0;
    logic s1_req, s1_ne;
    logic [18:0] s1_vppn, r_vppn, w_vppn, f_va, rd_vppn;
    logic [9:0] s1_asid, r_asid, w_asid, f_asid, rd_asid;
    logic [3:0] s1_index, r_index, w_index, srch_idx;
    logic [5:0] r_ps, w_ps, rd_ps;
    logic r_ne, r_g, we, w_ne, w_g, fe, srch_we, srch_ne, rd_we, rd_ne, rd_g, done;
    PhytranItem r_phytran0, r_phytran1, w_phytran0, w_phytran1, rd_phytran0, rd_phytran1;
    logic [2:0] f_op;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    typedef struct {
        int           kind;
        int           acc;
        logic [127:0] data;
    } exp_t;
    exp_t q[$];

    // Static TLB contents
    logic       m_e[16];
    logic [18:0] m_vppn[16];
    logic [9:0] m_asid[16];
    logic       m_g[16];
    logic [5:0] m_ps[16];
    PhytranItem m_p0[16], m_p1[16];

    tlb_op_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn), .csr_idx(csr_idx),
        .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .csr_g0(csr_g0), .csr_g1(csr_g1), .csr_refill(csr_refill),
        .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
        .s1_index(s1_index), .s1_ne(s1_ne), .r_index(r_index),
        .r_ps(r_ps), .r_asid(r_asid), .r_ne(r_ne), .r_g(r_g), .r_vppn(r_vppn),
        .r_phytran0(r_phytran0), .r_phytran1(r_phytran1),
        .we(we), .w_index(w_index), .w_ps(w_ps), .w_ne(w_ne), .w_asid(w_asid),
        .w_vppn(w_vppn), .w_g(w_g), .w_phytran0(w_phytran0), .w_phytran1(w_phytran1),
        .fe(fe), .f_op(f_op), .f_asid(f_asid), .f_va(f_va),
        .srch_we(srch_we), .srch_idx(srch_idx), .srch_ne(srch_ne),
        .rd_we(rd_we), .rd_ps(rd_ps), .rd_asid(rd_asid), .rd_ne(rd_ne), .rd_g(rd_g),
        .rd_vppn(rd_vppn), .rd_phytran0(rd_phytran0), .rd_phytran1(rd_phytran1),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Search responder: a miss reports index 0
    always_comb begin
        s1_ne    = 1'b1;
        s1_index = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (s1_ne && m_e[i] && m_vppn[i] == s1_vppn && (m_g[i] || m_asid[i] == s1_asid)) begin
                s1_ne    = 1'b0;
                s1_index = 4'(i);
            end
        end
    end

    // Read responder: invalid entries return zeros with ne set
    always_comb begin
        r_ne       = ~m_e[r_index];
        r_ps       = m_e[r_index] ? m_ps[r_index]   : 6'd0;
        r_asid     = m_e[r_index] ? m_asid[r_index] : 10'd0;
        r_g        = m_e[r_index] ? m_g[r_index]    : 1'b0;
        r_vppn     = m_e[r_index] ? m_vppn[r_index] : 19'd0;
        r_phytran0 = m_e[r_index] ? m_p0[r_index]   : '0;
        r_phytran1 = m_e[r_index] ? m_p1[r_index]   : '0;
    end

    logic [4:0]   mon_strb, mon_exp_strb;
    logic [127:0] mon_obs;
    exp_t         mon_e;

    // Scoreboard: every done pops one expectation
    always @(negedge clk) begin
        if (reset) begin
            mon_strb = {s1_req, srch_we, rd_we, we, fe};
            if (done) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    passes++;
                    mon_e = q.pop_front();
                    case (mon_e.kind)
                        K_SRCH: begin mon_exp_strb = 5'b01000; mon_obs = {123'd0, srch_ne, srch_idx}; end
                        K_RD:   begin mon_exp_strb = 5'b00100;
                                      mon_obs = {39'd0, rd_ps, rd_asid, rd_ne, rd_g, rd_vppn, rd_phytran0, rd_phytran1}; end
                        K_WR:   begin mon_exp_strb = 5'b00010;
                                      mon_obs = {35'd0, w_index, w_ne, w_g, w_asid, w_vppn, w_ps, w_phytran0, w_phytran1}; end
                        K_INV:  begin mon_exp_strb = 5'b00001; mon_obs = {96'd0, f_op, f_asid, f_va}; end
                        default: begin mon_exp_strb = 5'b00000; mon_obs = 128'd0; end
                    endcase
                    checks++;
                    if (mon_strb !== mon_exp_strb)
                        $display("FAIL strobes kind=%0d got %b want %b", mon_e.kind, mon_strb, mon_exp_strb);
                    else passes++;
                    checks++;
                    if (cyc - mon_e.acc != ((mon_e.kind == K_SRCH || mon_e.kind == K_RD) ? 2 : 1))
                        $display("FAIL latency kind=%0d got %0d", mon_e.kind, cyc - mon_e.acc);
                    else passes++;
                    if (mon_e.kind != K_ILL) begin
                        checks++;
                        if (mon_obs !== mon_e.data)
                            $display("FAIL data kind=%0d got %h want %h", mon_e.kind, mon_obs, mon_e.data);
                        else passes++;
                    end
                end
            end else begin
                checks++;
                if (mon_strb[3:0] !== 4'b0000)
                    $display("FAIL stray_strobe got %b at cycle %0d", mon_strb, cyc);
                else passes++;
            end
        end
    end

    task automatic issue(input logic [2:0] code, input int kind, input logic [127:0] data);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++;
            $display("FAIL issue_timeout op_ready got %b want 1", op_ready);
            return;
        end
        op_code  = code;
        op_valid = 1'b1;
        e.kind = kind;
        e.acc  = cyc;
        e.data = data;
        q.push_back(e);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            $display("FAIL drain_timeout pending got %0d want 0", q.size());
            q.delete();
        end else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", op_ready); else passes++;
        checks++;
        if ({done, s1_req, srch_we, rd_we, we, fe} !== 6'd0)
            $display("FAIL reset_strobes got %b want 000000", {done, s1_req, srch_we, rd_we, we, fe});
        else passes++;
        checks++;
        if ({srch_idx, srch_ne, rd_ne, rd_vppn, w_index} !== 29'd0)
            $display("FAIL reset_results got %h want 0", {srch_idx, srch_ne, rd_ne, rd_vppn, w_index});
        else passes++;
    endtask

    task automatic test_srch();
        csr_ehi_vppn = 19'h12345;
        csr_asid     = 10'd3;
        issue(OP_SRCH, K_SRCH, {123'd0, 1'b0, 4'd5});
        checks++;
        if ({s1_req, s1_vppn, s1_asid} !== {1'b1, 19'h12345, 10'd3})
            $display("FAIL srch_port got %b/%h/%h want 1/12345/003", s1_req, s1_vppn, s1_asid);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (s1_req !== 1'b0) $display("FAIL s1_req_width got %b want 0", s1_req); else passes++;
        drain();
        csr_asid = 10'd4;
        issue(OP_SRCH, K_SRCH, {123'd0, 1'b1, 4'd0});
        drain();
        csr_ehi_vppn = 19'h0ABCD;
        csr_asid     = 10'd7;
        issue(OP_SRCH, K_SRCH, {123'd0, 1'b0, 4'd2});
        drain();
    endtask

    task automatic test_rd();
        csr_idx = 4'd9;
        issue(OP_RD, K_RD, {39'd0, 6'd0, 10'd0, 1'b1, 1'b0, 19'd0, 26'd0, 26'd0});
        drain();
        csr_idx = 4'd2;
        issue(OP_RD, K_RD, {39'd0, 6'd21, 10'h1F, 1'b0, 1'b1, 19'h0ABCD, 26'h3333333, 26'h1444444});
        drain();
    endtask

    task automatic test_write();
        csr_idx = 4'd7; csr_ne = 1'b1; csr_refill = 1'b1; csr_g0 = 1'b1; csr_g1 = 1'b0;
        csr_asid = 10'd3; csr_ehi_vppn = 19'h12345; csr_ps = 6'd12;
        csr_elo0 = PhytranItem'(26'h12ABCDE);
        csr_elo1 = PhytranItem'(26'h3F00F0F);
        issue(OP_WR, K_WR, {35'd0, 4'd7, 1'b0, 1'b0, 10'd3, 19'h12345, 6'd12, 26'h12ABCDE, 26'h3F00F0F});
        drain();
        csr_idx = 4'd3; csr_refill = 1'b0; csr_g1 = 1'b1;
        issue(OP_WR, K_WR, {35'd0, 4'd3, 1'b1, 1'b1, 10'd3, 19'h12345, 6'd12, 26'h12ABCDE, 26'h3F00F0F});
        drain();
    endtask

    task automatic test_fill();
        logic [3:0] exp_ptr = 4'd0;
        csr_idx = 4'd11; csr_ne = 1'b0; csr_refill = 1'b0; csr_g0 = 1'b1; csr_g1 = 1'b1;
        csr_asid = 10'h155; csr_ehi_vppn = 19'h5A5A5; csr_ps = 6'd14;
        for (int i = 0; i < 17; i++) begin
            issue(OP_FILL, K_WR, {35'd0, exp_ptr, 1'b0, 1'b1, 10'h155, 19'h5A5A5, 6'd14, 26'h12ABCDE, 26'h3F00F0F});
            drain();
            exp_ptr = (exp_ptr == 4'd15) ? 4'd0 : exp_ptr + 4'd1;
        end
    endtask

    task automatic test_inv();
        inv_op = 3'd5; inv_asid = 10'h2A; inv_va = 19'h7FFFF;
        issue(OP_INV, K_INV, {96'd0, 3'd5, 10'h2A, 19'h7FFFF});
        checks++;
        if (fe !== 1'b1) $display("FAIL inv_fe_high got %b want 1", fe); else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (fe !== 1'b0) $display("FAIL inv_fe_width got %b want 0", fe); else passes++;
        drain();
        inv_op = 3'd2; inv_asid = 10'h301; inv_va = 19'h00010;
        issue(OP_INV, K_INV, {96'd0, 3'd2, 10'h301, 19'h00010});
        drain();
    endtask

    task automatic test_illegal();
        issue(3'd5, K_ILL, 128'd0);
        drain();
        issue(3'd7, K_ILL, 128'd0);
        drain();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        csr_idx = 4'd6; csr_ne = 1'b0; csr_refill = 1'b0; csr_g0 = 1'b0; csr_g1 = 1'b1;
        @(negedge clk);
        op_code  = OP_WR;
        op_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.kind = K_WR;
            e.acc  = cyc + 2 * k;
            e.data = {35'd0, 4'd6, 1'b0, 1'b0, 10'h155, 19'h5A5A5, 6'd14, 26'h12ABCDE, 26'h3F00F0F};
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b0) $display("FAIL b2b_ready got %b want 0", op_ready); else passes++;
        repeat (4) @(posedge clk);
        #1 op_valid = 1'b0;
        drain();
    endtask

    task automatic test_mid_reset();
        csr_ehi_vppn = 19'h12345; csr_asid = 10'd3;
        issue(OP_SRCH, K_SRCH, {123'd0, 1'b0, 4'd5});
        drain();
        @(negedge clk);
        csr_idx  = 4'd2;
        op_code  = OP_RD;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        checks++;
        if (op_ready !== 1'b0) $display("FAIL rd_busy got %b want 0", op_ready); else passes++;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        checks++;
        if (op_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", op_ready); else passes++;
        checks++;
        if ({srch_idx, rd_vppn, done} !== 24'd0)
            $display("FAIL abort_clear got %h want 0", {srch_idx, rd_vppn, done});
        else passes++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else passes++;
        end
        csr_ehi_vppn = 19'h5A5A5; csr_asid = 10'h155; csr_g0 = 1'b1;
        issue(OP_FILL, K_WR, {35'd0, 4'd0, 1'b0, 1'b1, 10'h155, 19'h5A5A5, 6'd14, 26'h12ABCDE, 26'h3F00F0F});
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_e[i] = 1'b0; m_vppn[i] = 19'd0; m_asid[i] = 10'd0; m_g[i] = 1'b0;
            m_ps[i] = 6'd0; m_p0[i] = '0; m_p1[i] = '0;
        end
        m_e[5] = 1'b1; m_vppn[5] = 19'h12345; m_asid[5] = 10'd3; m_g[5] = 1'b0;
        m_ps[5] = 6'd12; m_p0[5] = PhytranItem'(26'h0111111); m_p1[5] = PhytranItem'(26'h0222222);
        m_e[2] = 1'b1; m_vppn[2] = 19'h0ABCD; m_asid[2] = 10'h1F; m_g[2] = 1'b1;
        m_ps[2] = 6'd21; m_p0[2] = PhytranItem'(26'h3333333); m_p1[2] = PhytranItem'(26'h1444444);

        test_reset();
        test_srch();
        test_rd();
        test_write();
        test_fill();
        test_inv();
        test_illegal();
        test_back_to_back();
        test_mid_reset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
